// File: rtl/text_overlay_renderer.sv
// text_overlay_renderer: character-cell text overlay for the VGA pixel path.
// A COLS x ROWS buffer of (code, blink) cells is rendered through a fixed
// 8x8 font, magnified by 2^SCALE_LOG2, with a two-clock pixel latency.
module text_overlay_renderer #(
  parameter int COLS         = 16,
  parameter int ROWS         = 4,
  parameter int SCALE_LOG2   = 1,
  parameter int ORIGIN_X     = 0,
  parameter int ORIGIN_Y     = 0,
  parameter int BLINK_FRAMES = 30,
  parameter int XW           = 10,
  parameter int YW           = 10,
  localparam int CELLS       = COLS * ROWS,
  localparam int AW          = (CELLS > 1) ? $clog2(CELLS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [XW-1:0] pixel_x,
  input  logic [YW-1:0] pixel_y,
  input  logic          video_on,
  input  logic          frame_start,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_char,
  input  logic          wr_blink,
  output logic          pixel_on,
  output logic          pixel_valid
);
  localparam int SHIFT = 3 + SCALE_LOG2;
  localparam int WIN_W = COLS << SHIFT;
  localparam int WIN_H = ROWS << SHIFT;
  localparam int BW    = $clog2(BLINK_FRAMES + 1);
  localparam logic [XW:0]   OX         = (XW + 1)'(ORIGIN_X);
  localparam logic [YW:0]   OY         = (YW + 1)'(ORIGIN_Y);
  localparam logic [XW:0]   WX         = (XW + 1)'(WIN_W);
  localparam logic [YW:0]   WY         = (YW + 1)'(WIN_H);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [7:0]    BLANK      = 8'h20;

  // The text window must fit inside the pixel coordinate range.
  generate
    if (ORIGIN_X + WIN_W > (1 << XW)) begin : g_bad_x
      $error("text window exceeds pixel_x range");
    end
    if (ORIGIN_Y + WIN_H > (1 << YW)) begin : g_bad_y
      $error("text window exceeds pixel_y range");
    end
  endgenerate

  // Font rows 0..6 packed MSB-first; row 7 is always blank.
  function automatic logic [7:0] glyph_bits(input logic [7:0] code, input logic [2:0] grow);
    logic [55:0] rows;
    case (code)
      8'h00:   rows = 56'h3C666E7666663C;
      8'h01:   rows = 56'h0C1C0C0C0C0C1E;
      8'h02:   rows = 56'h3C66060C18307E;
      8'h03:   rows = 56'h3C66061C06663C;
      8'h04:   rows = 56'h0C1C2C4C7E0C0C;
      8'h05:   rows = 56'h7E607C0606663C;
      8'h06:   rows = 56'h3C607C6666663C;
      8'h07:   rows = 56'h7E060C18303030;
      8'h08:   rows = 56'h3C66663C66663C;
      8'h09:   rows = 56'h3C66663E060C38;
      8'h41:   rows = 56'h183C66667E6666;
      8'h42:   rows = 56'h7C66667C66667C;
      8'h43:   rows = 56'h3C66606060663C;
      8'h44:   rows = 56'h786C6666666C78;
      8'h45:   rows = 56'h7E60607C60607E;
      8'h46:   rows = 56'h7E60607C606060;
      8'h49:   rows = 56'h3C18181818183C;
      8'h4C:   rows = 56'h6060606060607E;
      8'h4E:   rows = 56'h66767E7E6E6666;
      8'h4F:   rows = 56'h3C66666666663C;
      8'h54:   rows = 56'h7E181818181818;
      8'h5A:   rows = 56'h7E060C1830607E;
      default: rows = 56'h0;
    endcase
    if (grow == 3'd7) begin
      glyph_bits = 8'h00;
    end else begin
      rows       = rows << {grow, 3'b000};
      glyph_bits = rows[55:48];
    end
  endfunction

  logic [7:0]    cell_char_r  [CELLS];
  logic          cell_blink_r [CELLS];
  logic [BW-1:0] blink_cnt_r;
  logic          blink_phase_r;

  logic [XW:0]   dx_s;
  logic [YW:0]   dy_s;
  logic          in_win_s;
  logic [XW-1:0] col_s;
  logic [YW-1:0] row_s;
  logic [31:0]   cell_s;
  logic [2:0]    bit_x_s;
  logic [2:0]    glyph_row_s;
  logic [7:0]    rd_char_s;
  logic          rd_blink_s;

  logic [7:0]    s1_char_r;
  logic          s1_blink_r;
  logic          s1_in_win_r;
  logic          s1_video_r;
  logic [2:0]    s1_bit_x_r;
  logic [2:0]    s1_glyph_row_r;
  logic [7:0]    glyph_s;
  logic          glyph_pix_s;

  // Window test, cell address and glyph coordinates; the extra MSB flags pixels left/above the origin.
  always_comb begin
    dx_s        = {1'b0, pixel_x} - OX;
    dy_s        = {1'b0, pixel_y} - OY;
    in_win_s    = ~dx_s[XW] && (dx_s < WX) && ~dy_s[YW] && (dy_s < WY);
    col_s       = dx_s[XW-1:0] >> SHIFT;
    row_s       = dy_s[YW-1:0] >> SHIFT;
    bit_x_s     = dx_s[SCALE_LOG2 +: 3];
    glyph_row_s = dy_s[SCALE_LOG2 +: 3];
    cell_s      = in_win_s ? (32'(row_s) * 32'(COLS) + 32'(col_s)) : 32'd0;
    rd_char_s   = BLANK;
    rd_blink_s  = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      rd_char_s  = (cell_s == 32'(i)) ? cell_char_r[i]  : rd_char_s;
      rd_blink_s = (cell_s == 32'(i)) ? cell_blink_r[i] : rd_blink_s;
    end
  end

  // Character buffer: cleared to blank on reset; out-of-range addresses match no cell.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CELLS; i++) begin
        cell_char_r[i]  <= BLANK;
        cell_blink_r[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CELLS; i++) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          cell_char_r[i]  <= wr_char;
          cell_blink_r[i] <= wr_blink;
        end else begin
          cell_char_r[i]  <= cell_char_r[i];
          cell_blink_r[i] <= cell_blink_r[i];
        end
      end
    end
  end

  // Blink timebase: phase toggles once every BLINK_FRAMES frame_start pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r   <= blink_cnt_r + BW'(1);
      end
    end
  end

  // Stage 1: capture the cell contents (pre-write value) and the pixel's glyph coordinates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_char_r      <= 8'h00;
      s1_blink_r     <= 1'b0;
      s1_in_win_r    <= 1'b0;
      s1_video_r     <= 1'b0;
      s1_bit_x_r     <= 3'd0;
      s1_glyph_row_r <= 3'd0;
    end else begin
      s1_char_r      <= rd_char_s;
      s1_blink_r     <= rd_blink_s;
      s1_in_win_r    <= in_win_s;
      s1_video_r     <= video_on;
      s1_bit_x_r     <= bit_x_s;
      s1_glyph_row_r <= glyph_row_s;
    end
  end

  // Glyph lookup for the stage-1 pixel; MSB of a font row is the leftmost pixel.
  always_comb begin
    glyph_s     = glyph_bits(s1_char_r, s1_glyph_row_r);
    glyph_pix_s = glyph_s[3'd7 - s1_bit_x_r];
  end

  // Stage 2: final pixel with blink suppression, plus the delayed video qualifier.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_on    <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_on    <= s1_in_win_r & s1_video_r & glyph_pix_s & ~(s1_blink_r & blink_phase_r);
      pixel_valid <= s1_video_r;
    end
  end

endmodule

// File: tb/tb_text_overlay_renderer.sv
// Bench for text_overlay_renderer: two instances (default geometry, and a
// 12x5 window at (8,4) with BLINK_FRAMES=2) share all inputs. Expectations
// come from directed tables and a coordinate-arithmetic reference model.
module tb_text_overlay_renderer;
  localparam int S = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, frame_start, wr_en, wr_blink;
  logic [5:0] wr_addr;
  logic [7:0] wr_char;
  logic       on0, valid0, on1, valid1;

  always #5 clk = ~clk;

  text_overlay_renderer dut (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_start(frame_start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_char(wr_char), .wr_blink(wr_blink),
    .pixel_on(on0), .pixel_valid(valid0)
  );

  text_overlay_renderer #(
    .COLS(12), .ROWS(5), .ORIGIN_X(8), .ORIGIN_Y(4), .BLINK_FRAMES(2)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_start(frame_start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_char(wr_char), .wr_blink(wr_blink),
    .pixel_on(on1), .pixel_valid(valid1)
  );

  typedef struct {
    int   x;
    int   y;
    logic von;
    logic exp;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  string      tag   = "init";
  logic [7:0] font  [256][8];
  logic [8:0] mem_m [2][64];
  int         pulses;
  logic [1:0] e1_on = 2'b00, e1_val = 2'b00, e2_on = 2'b00, e2_val = 2'b00;

  function automatic int cols_of(int k);  return (k == 0) ? 16 : 12; endfunction
  function automatic int rows_of(int k);  return (k == 0) ? 4 : 5;   endfunction
  function automatic int ox_of(int k);    return (k == 0) ? 0 : 8;   endfunction
  function automatic int oy_of(int k);    return (k == 0) ? 0 : 4;   endfunction
  function automatic int blinkf_of(int k); return (k == 0) ? 30 : 2; endfunction

  task automatic set_glyph(input int code, input logic [63:0] bits);
    for (int r = 0; r < 8; r++) font[code][r] = bits[63 - 8*r -: 8];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) mem_m[k][i] = {1'b0, 8'h20};
    pulses = 0;
  endtask

  // Reference: pixel value from plain division/modulo on the window geometry.
  function automatic logic model_on(int k, int x, int y, logic von);
    int cs, c, r, gx, gy;
    logic [8:0] ent;
    logic       phase;
    cs = 8 * (2 ** S);
    if (!von) return 1'b0;
    if (x < ox_of(k) || y < oy_of(k)) return 1'b0;
    if (x >= ox_of(k) + cols_of(k) * cs || y >= oy_of(k) + rows_of(k) * cs) return 1'b0;
    c  = (x - ox_of(k)) / cs;
    r  = (y - oy_of(k)) / cs;
    gx = ((x - ox_of(k)) % cs) / (2 ** S);
    gy = ((y - oy_of(k)) % cs) / (2 ** S);
    ent   = mem_m[k][r * cols_of(k) + c];
    phase = ((pulses / blinkf_of(k)) % 2) == 1;
    if (ent[8] && phase) return 1'b0;
    return font[ent[7:0]][gy][7 - gx];
  endfunction

  task automatic check(input string name, input int k, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s/%s inst%0d got=%0b want=%0b", tag, name, k, got, want);
    end
  endtask

  // One pixel clock: check outputs due now, drive new inputs, advance the models.
  // x0/x1 >= 0 give an explicit expected pixel_on for instance 0/1.
  task automatic cycle(input int x, input int y, input logic von, input logic fs,
                       input logic we, input int wa, input logic [7:0] wc, input logic wb,
                       input int x0, input int x1);
    check("pixel_on", 0, on0, e2_on[0]);
    check("pixel_valid", 0, valid0, e2_val[0]);
    check("pixel_on", 1, on1, e2_on[1]);
    check("pixel_valid", 1, valid1, e2_val[1]);
    e2_on  = e1_on;
    e2_val = e1_val;
    pixel_x = x[9:0]; pixel_y = y[9:0]; video_on = von; frame_start = fs;
    wr_en = we; wr_addr = wa[5:0]; wr_char = wc; wr_blink = wb;
    if (!reset_n) begin
      model_reset();
      e1_on  = 2'b00;
      e1_val = 2'b00;
    end else begin
      if (fs) pulses++;
      for (int k = 0; k < 2; k++) begin
        e1_on[k]  = model_on(k, x, y, von);
        e1_val[k] = von;
      end
      if (x0 >= 0) e1_on[0] = (x0 == 1);
      if (x1 >= 0) e1_on[1] = (x1 == 1);
      if (we)
        for (int k = 0; k < 2; k++)
          if (wa < cols_of(k) * rows_of(k)) mem_m[k][wa] = {wb, wc};
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic px(input int x, input int y, input logic von, input int x0, input int x1);
    cycle(x, y, von, 1'b0, 1'b0, 0, 8'h00, 1'b0, x0, x1);
  endtask

  task automatic wr(input int a, input logic [7:0] c, input logic b);
    cycle(0, 0, 1'b0, 1'b0, 1'b1, a, c, b, -1, -1);
  endtask

  task automatic fpulse();
    cycle(0, 0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0, -1, -1);
  endtask

  initial begin
    vec_t tab[$];
    logic [7:0] codes [25] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                               8'h08, 8'h09, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
                               8'h49, 8'h4C, 8'h4E, 8'h4F, 8'h54, 8'h5A, 8'h20, 8'h55, 8'hFF};

    for (int c = 0; c < 256; c++)
      for (int r = 0; r < 8; r++) font[c][r] = 8'h00;
    set_glyph(8'h00, 64'h3C666E7666663C00); set_glyph(8'h01, 64'h0C1C0C0C0C0C1E00);
    set_glyph(8'h02, 64'h3C66060C18307E00); set_glyph(8'h03, 64'h3C66061C06663C00);
    set_glyph(8'h04, 64'h0C1C2C4C7E0C0C00); set_glyph(8'h05, 64'h7E607C0606663C00);
    set_glyph(8'h06, 64'h3C607C6666663C00); set_glyph(8'h07, 64'h7E060C1830303000);
    set_glyph(8'h08, 64'h3C66663C66663C00); set_glyph(8'h09, 64'h3C66663E060C3800);
    set_glyph(8'h41, 64'h183C66667E666600); set_glyph(8'h42, 64'h7C66667C66667C00);
    set_glyph(8'h43, 64'h3C66606060663C00); set_glyph(8'h44, 64'h786C6666666C7800);
    set_glyph(8'h45, 64'h7E60607C60607E00); set_glyph(8'h46, 64'h7E60607C60606000);
    set_glyph(8'h49, 64'h3C18181818183C00); set_glyph(8'h4C, 64'h6060606060607E00);
    set_glyph(8'h4E, 64'h66767E7E6E666600); set_glyph(8'h4F, 64'h3C66666666663C00);
    set_glyph(8'h54, 64'h7E18181818181800); set_glyph(8'h5A, 64'h7E060C1830607E00);

    // Directed vectors for instance 0 (expected values from the glyph rows).
    for (int x = 0; x < 16; x++)  tab.push_back('{x, 12, 1'b1, (x >= 6 && x <= 13)});
    for (int x = 16; x < 32; x++) tab.push_back('{x, 16, 1'b1, (x >= 18 && x <= 29)});
    tab.push_back('{20, 16, 1'b0, 1'b0});
    tab.push_back('{24, 16, 1'b0, 1'b0});
    for (int x = 32; x < 48; x++) tab.push_back('{x, 12, 1'b1, 1'b0});
    for (int y = 0; y < 14; y++)  tab.push_back('{36, y, 1'b1, 1'b0});

    // Reset state.
    tag = "reset";
    reset_n = 1'b0;
    pixel_x = '0; pixel_y = '0; video_on = 1'b0; frame_start = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_char = '0; wr_blink = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) px(10, 12, 1'b1, -1, -1);
    reset_n = 1'b1;

    // Blank scan after reset; pixel_valid tracks video_on.
    tag = "blank_scan";
    for (int y = 0; y < 84; y += 4)
      for (int x = 0; x < 260; x += 2) px(x, y, ((x / 2) % 7) != 0, -1, -1);

    // Writes: digit 1, 'Z', unsupported code over 'A', out-of-range for instance 1.
    tag = "writes";
    wr(0, 8'h01, 1'b0);
    wr(17, 8'h5A, 1'b0);
    wr(2, 8'h41, 1'b0);
    wr(2, 8'h55, 1'b0);
    for (int a = 60; a < 64; a++) wr(a, 8'h41, 1'b0);

    tag = "table";
    foreach (tab[i]) px(tab[i].x, tab[i].y, tab[i].von, int'(tab[i].exp), -1);

    // Blink on instance 1 (BLINK_FRAMES=2): pixel (14,16) is rel (6,12) in cell 0.
    tag = "blink";
    wr(0, 8'h01, 1'b1);
    wr(1, 8'h01, 1'b0);
    px(14, 16, 1'b1, -1, 1);
    px(30, 16, 1'b1, -1, 1);
    fpulse(); fpulse();
    px(14, 16, 1'b1, -1, 0);
    px(30, 16, 1'b1, -1, 1);
    fpulse(); fpulse();
    px(14, 16, 1'b1, -1, 1);
    px(30, 16, 1'b1, -1, 1);

    // Same-cycle write and read of cell 0: old '1' first, then '7'.
    tag = "rbw";
    cycle(2, 0, 1'b1, 1'b0, 1'b1, 0, 8'h07, 1'b0, 0, -1);
    px(3, 0, 1'b1, 1, -1);
    px(4, 0, 1'b1, 1, -1);
    check("pre_reset_on", 0, on0, 1'b1);

    // Reset mid-line: outputs drop at once, buffer returns to blank.
    tag = "mid_reset";
    reset_n = 1'b0;
    #1;
    check("async_on", 0, on0, 1'b0);
    check("async_valid", 0, valid0, 1'b0);
    check("async_on", 1, on1, 1'b0);
    check("async_valid", 1, valid1, 1'b0);
    model_reset();
    e1_on = 2'b00; e1_val = 2'b00; e2_on = 2'b00; e2_val = 2'b00;
    px(3, 0, 1'b1, -1, -1);
    px(3, 0, 1'b1, -1, -1);
    reset_n = 1'b1;
    px(3, 0, 1'b1, 0, -1);
    px(4, 0, 1'b1, 0, -1);
    px(0, 0, 1'b0, -1, -1);

    // Randomized traffic against the reference model.
    tag = "random";
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 260), $urandom_range(0, 88), $urandom_range(0, 4) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 63),
            codes[$urandom_range(0, 24)], $urandom_range(0, 3) == 0, -1, -1);
    end
    px(0, 0, 1'b0, -1, -1);
    px(0, 0, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
